if_fetch_queue: RTL and testbench
=================================

// Module: if_fetch_queue
// PURPOSE
//  Next-generation instruction-fetch stage for the 5-stage MIPS pipeline. Sits between the inst_sram-like
//  request/response bus and ID. Supports up to MAX_OUTSTANDING pipelined fetches and buffers in-order
//  responses in an IBUF_DEPTH FIFO. Cancels in-flight responses on redirect (exception/eret/branch).
//  Replaces per-case stall/old-value registers with a single cancel counter.
// PARAMETERS
//  MAX_OUTSTANDING  2             max accepted-but-unanswered requests (1..7)
//  IBUF_DEPTH       4             instruction FIFO entries (power of 2, >= MAX_OUTSTANDING)
//  RESET_PC         32'hbfc00000  first fetch address after reset
//  EX_ENTRY         32'hbfc00380  exception vector
// PORTS
//  clk              in   1   clock
//  reset            in   1   asynchronous, active-high reset
//  ds_allowin       in   1   ID can accept an instruction this cycle
//  fs_to_ds_valid   out  1   head FIFO entry valid
//  fs_to_ds_bus     out  70  {fs_ex[69], fs_excode[68:64], fs_inst[63:32], fs_pc[31:0]}
//  fs_stall         in   1   hazard unit: inhibit new requests (responses still accepted)
//  ex_taken         in   1   redirect to EX_ENTRY
//  eret_taken       in   1   redirect to epc
//  epc              in   32  eret target
//  br_taken         in   1   redirect to br_target; ID raises it only after the delay slot has left this block
//  br_target        in   32  branch target
//  inst_sram_req    out  1   request valid
//  inst_sram_addr   out  32  request address (= fetch pc)
//  inst_sram_addr_ok in  1   request accepted this cycle (when req=1)
//  inst_sram_data_ok in  1   one response returns, in request order
//  inst_sram_rdata  in   32  response data
// BEHAVIOUR
//  - Reset (async): fetch_pc=RESET_PC, FIFO empty, inflight=0, cancel=0, halt=0; req=0, fs_to_ds_valid=0.
//  - Redirect priority: ex_taken > eret_taken > br_taken. On any redirect: fetch_pc<=target, FIFO cleared,
//    cancel<=inflight_next, halt<=0, req forced 0 that cycle. inflight_next = inflight + acc - (data_ok).
//  - Issue: req = !redirect && !fs_stall && !halt && fetch_pc[1:0]==0 && inflight<MAX_OUTSTANDING
//    && (fifo_count + inflight) < IBUF_DEPTH. acc = req && addr_ok -> fetch_pc+=4, pc pushed to pc-tag FIFO.
//  - Response: data_ok with cancel!=0 -> drop, cancel-=1. Else enqueue {0,0,rdata,tag_pc}. inflight-=1 either way.
//    Room reservation guarantees FIFO never overflows; data_ok with inflight==0 is an assertion failure.
//  - Misaligned fetch_pc (bits[1:0]!=0) with no request in flight: enqueue {1,5'h04,32'h0,fetch_pc} once
//    (needs a free slot), set halt=1; no further requests until redirect.
//  - Dequeue: fs_to_ds_valid = !fifo_empty && !redirect; pop when valid && ds_allowin. Same-cycle push+pop
//    legal at full/empty. Latency: addr_ok at cycle N, data_ok at N+k -> earliest fs_to_ds_valid at N+k+1.
//  - data_ok coincident with redirect: counts toward cancel math (inflight_next), data never enqueued.
//  - addr_ok and data_ok coincident: both counters update; inflight unchanged.
//  - Counters 3-bit; pointers log2(IBUF_DEPTH)+1 bits, wrap naturally.
// TESTING
//  1 Reset release, 1-cycle memory: addr seq bfc00000,bfc00004,...; ID sees pcs in order, 1 inst/cycle sustained.
//  2 ds_allowin=0 for 10 cycles, MAX_OUTSTANDING=2, IBUF_DEPTH=4: at most 4 entries buffered, req drops; resume: no loss/dup.
//  3 Two requests in flight, ex_taken pulse -> both responses dropped; next ID pc = bfc00380.
//  4 eret_taken with epc=0x80001002 -> one entry {ex=1,excode=04,pc=80001002}, no requests until next redirect.
//  5 ex_taken and br_taken same cycle -> target bfc00380; data_ok same cycle also dropped.
//  6 Assert reset with 2 requests in flight -> outputs 0 immediately; after release, first addr = RESET_PC.

Source files
------------

// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: pipelined inst_sram requests, in-order response FIFO toward ID,
// redirect handling through a single cancel counter for responses still in flight.
module if_fetch_queue #(
  parameter int          MAX_OUTSTANDING = 2,
  parameter int          IBUF_DEPTH      = 4,
  parameter logic [31:0] RESET_PC        = 32'hbfc00000,
  parameter logic [31:0] EX_ENTRY        = 32'hbfc00380
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ds_allowin,
  output logic        fs_to_ds_valid,
  output logic [69:0] fs_to_ds_bus,
  input  logic        fs_stall,
  input  logic        ex_taken,
  input  logic        eret_taken,
  input  logic [31:0] epc,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        inst_sram_req,
  output logic [31:0] inst_sram_addr,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata
);
  localparam int AW = $clog2(IBUF_DEPTH);
  localparam int SW = AW + 4;

  logic [31:0] fetch_pc;
  logic [2:0]  inflight, cancel, inflight_next;
  logic        halt;

  logic [69:0] ibuf [IBUF_DEPTH];
  logic [AW:0] wptr, rptr, fifo_count;
  logic        fifo_empty, fifo_full;

  // Tag FIFO holds the pc of every accepted request, cancelled or not, so it pops on every data_ok.
  logic [31:0] tag_mem [8];
  logic [2:0]  tag_w, tag_r;

  logic        redirect, misaligned, acc, resp_push, exc_push, push, pop;
  logic [31:0] redirect_pc;
  logic [SW-1:0] reserved;
  logic [69:0] push_data;

  assign fifo_count = wptr - rptr;
  assign fifo_empty = (fifo_count == '0);
  assign fifo_full  = (fifo_count == (AW+1)'(IBUF_DEPTH));
  assign reserved   = SW'(fifo_count) + SW'(inflight);

  assign redirect    = ex_taken || eret_taken || br_taken;
  assign redirect_pc = ex_taken ? EX_ENTRY : (eret_taken ? epc : br_target);
  assign misaligned  = (fetch_pc[1:0] != 2'b00);

  assign inst_sram_req  = !reset && !redirect && !fs_stall && !halt && !misaligned
                          && (inflight < 3'(MAX_OUTSTANDING)) && (reserved < SW'(IBUF_DEPTH));
  assign inst_sram_addr = fetch_pc;
  assign acc            = inst_sram_req && inst_sram_addr_ok;
  assign inflight_next  = inflight + 3'(acc) - 3'(inst_sram_data_ok);

  assign resp_push = inst_sram_data_ok && !redirect && (cancel == 3'd0);
  assign exc_push  = misaligned && !halt && (inflight == 3'd0) && !redirect && !fifo_full;
  assign push      = resp_push || exc_push;
  assign push_data = exc_push ? {1'b1, 5'h04, 32'h0, fetch_pc}
                              : {1'b0, 5'h00, inst_sram_rdata, tag_mem[tag_r]};

  assign fs_to_ds_valid = !fifo_empty && !redirect;
  assign fs_to_ds_bus   = ibuf[rptr[AW-1:0]];
  assign pop            = fs_to_ds_valid && ds_allowin;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      inflight <= '0;
      cancel   <= '0;
      halt     <= 1'b0;
      wptr     <= '0;
      rptr     <= '0;
      tag_w    <= '0;
      tag_r    <= '0;
    end else begin
      inflight <= inflight_next;
      if (acc) tag_w <= tag_w + 3'd1;
      if (inst_sram_data_ok) tag_r <= tag_r + 3'd1;
      if (redirect) begin
        fetch_pc <= redirect_pc;
        wptr     <= '0;
        rptr     <= '0;
        cancel   <= inflight_next;
        halt     <= 1'b0;
      end else begin
        if (acc) fetch_pc <= fetch_pc + 32'd4;
        if (push) wptr <= wptr + 1'b1;
        if (pop) rptr <= rptr + 1'b1;
        if (inst_sram_data_ok && (cancel != 3'd0)) cancel <= cancel - 3'd1;
        if (exc_push) halt <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (acc) tag_mem[tag_w] <= fetch_pc;
    if (push && !redirect) ibuf[wptr[AW-1:0]] <= push_data;
  end

  assert property (@(posedge clk) disable iff (reset) !(inst_sram_data_ok && (inflight == 3'd0)));

endmodule

// File: tb/tb_if_fetch_queue.sv
// Randomized bench for if_fetch_queue: a transaction-level model (request list + ID-visible queue)
// predicts every output each cycle; scenario tasks add targeted checks.
module tb_if_fetch_queue;
  localparam logic [31:0] RST_PC = 32'hbfc00000;
  localparam logic [31:0] EX_PC  = 32'hbfc00380;

  logic        clk = 0, reset = 1;
  logic        ds_allowin = 0, fs_stall = 0, ex_taken = 0, eret_taken = 0, br_taken = 0;
  logic [31:0] epc = 0, br_target = 0, inst_sram_rdata = 0;
  logic        inst_sram_addr_ok = 0, inst_sram_data_ok = 0;
  logic        fs_to_ds_valid, inst_sram_req;
  logic [69:0] fs_to_ds_bus;
  logic [31:0] inst_sram_addr;

  if_fetch_queue #(.MAX_OUTSTANDING(2), .IBUF_DEPTH(4), .RESET_PC(RST_PC), .EX_ENTRY(EX_PC)) dut (
    .clk(clk), .reset(reset), .ds_allowin(ds_allowin), .fs_to_ds_valid(fs_to_ds_valid),
    .fs_to_ds_bus(fs_to_ds_bus), .fs_stall(fs_stall), .ex_taken(ex_taken), .eret_taken(eret_taken),
    .epc(epc), .br_taken(br_taken), .br_target(br_target), .inst_sram_req(inst_sram_req),
    .inst_sram_addr(inst_sram_addr), .inst_sram_addr_ok(inst_sram_addr_ok),
    .inst_sram_data_ok(inst_sram_data_ok), .inst_sram_rdata(inst_sram_rdata));

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; bit stale; } req_t;
  req_t        mem[$];
  logic [69:0] dq[$];
  logic [31:0] m_pc;
  bit          m_halt;
  int          checks = 0, failures = 0, cyc = 0, last_due = 0, pops = 0;
  bit          popped;
  logic [69:0] popped_bus;

  bit          k_allow = 1, k_stall = 0, k_ex = 0, k_eret = 0, k_br = 0, k_aok_rand = 0;
  logic [31:0] k_epc = 0, k_brt = 0;
  int          k_lat_min = 1, k_lat_max = 1;

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h3c1d_5e7a;
  endfunction

  task automatic model_reset();
    mem.delete(); dq.delete();
    m_pc = RST_PC; m_halt = 0; last_due = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    inst_sram_addr_ok = 0; inst_sram_data_ok = 0;
    ex_taken = 0; eret_taken = 0; br_taken = 0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 0;
  endtask

  // One clock of stimulus plus per-cycle prediction of valid/bus/req/addr.
  task automatic run_cycle();
    logic        exp_req, exp_valid, redir, misal;
    logic [31:0] tgt;
    req_t        h, n;
    int          pre_dq, pre_mem;
    @(negedge clk);
    ds_allowin = k_allow; fs_stall = k_stall;
    ex_taken = k_ex; eret_taken = k_eret; br_taken = k_br;
    epc = k_epc; br_target = k_brt;
    inst_sram_addr_ok = k_aok_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    inst_sram_data_ok = (mem.size() > 0) && (mem[0].due <= cyc);
    inst_sram_rdata   = inst_sram_data_ok ? mem_word(mem[0].addr) : $urandom;
    #1;
    redir   = k_ex || k_eret || k_br;
    tgt     = k_ex ? EX_PC : (k_eret ? k_epc : k_brt);
    pre_dq  = dq.size();
    pre_mem = mem.size();
    exp_valid = (pre_dq > 0) && !redir;
    exp_req   = !redir && !k_stall && !m_halt && (m_pc[1:0] == 2'b00) && (pre_mem < 2)
                && (pre_dq + pre_mem < 4);
    misal     = !m_halt && (m_pc[1:0] != 2'b00) && (pre_mem == 0) && !redir && (pre_dq < 4);
    checks++;
    if (fs_to_ds_valid !== exp_valid) begin
      failures++; $display("FAIL valid cyc=%0d got=%b exp=%b", cyc, fs_to_ds_valid, exp_valid);
    end
    if (exp_valid) begin
      checks++;
      if (fs_to_ds_bus !== dq[0]) begin
        failures++; $display("FAIL bus cyc=%0d got=%h exp=%h", cyc, fs_to_ds_bus, dq[0]);
      end
    end
    checks++;
    if (inst_sram_req !== exp_req) begin
      failures++; $display("FAIL req cyc=%0d got=%b exp=%b", cyc, inst_sram_req, exp_req);
    end
    if (exp_req) begin
      checks++;
      if (inst_sram_addr !== m_pc) begin
        failures++; $display("FAIL addr cyc=%0d got=%h exp=%h", cyc, inst_sram_addr, m_pc);
      end
    end
    popped = 0;
    if (exp_valid && k_allow) begin
      popped_bus = dq.pop_front(); popped = 1; pops++;
    end
    if (inst_sram_data_ok) begin
      h = mem.pop_front();
      if (!redir && !h.stale) dq.push_back({1'b0, 5'd0, mem_word(h.addr), h.addr});
    end
    if (exp_req && inst_sram_addr_ok) begin
      n.addr = m_pc; n.stale = 0;
      n.due = cyc + $urandom_range(k_lat_min, k_lat_max);
      if (n.due < last_due) n.due = last_due;
      last_due = n.due;
      mem.push_back(n);
      m_pc = m_pc + 32'd4;
    end
    if (misal) begin
      dq.push_back({1'b1, 5'h04, 32'h0, m_pc}); m_halt = 1;
    end
    if (redir) begin
      foreach (mem[i]) mem[i].stale = 1;
      dq.delete(); m_pc = tgt; m_halt = 0;
    end
    @(posedge clk);
    cyc++;
  endtask

  task automatic wait_pop(input string name, input logic [69:0] exp);
    int n = 0;
    do begin run_cycle(); n++; end while (!popped && n < 40);
    checks++;
    if (!popped) begin
      failures++; $display("FAIL %s timeout waiting for ID pop", name);
    end else if (popped_bus !== exp) begin
      failures++; $display("FAIL %s got=%h exp=%h", name, popped_bus, exp);
    end
  endtask

  task automatic wait_inflight(input string name, input int want);
    int n = 0;
    while (mem.size() < want && n < 40) begin run_cycle(); n++; end
    checks++;
    if (mem.size() < want) begin
      failures++; $display("FAIL %s timeout reaching %0d in flight", name, want);
    end
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (inst_sram_req !== 1'b0 || fs_to_ds_valid !== 1'b0) begin
      failures++; $display("FAIL reset_outputs req=%b valid=%b exp 0/0", inst_sram_req, fs_to_ds_valid);
    end
    do_reset();
    #1;
    checks++;
    if (inst_sram_req !== 1'b1 || inst_sram_addr !== RST_PC) begin
      failures++; $display("FAIL reset_first_addr req=%b addr=%h exp 1/%h", inst_sram_req, inst_sram_addr, RST_PC);
    end
  endtask

  task automatic test_stream();
    int p0 = pops;
    logic [31:0] prev = RST_PC - 4;
    k_allow = 1; k_lat_min = 1; k_lat_max = 1; k_aok_rand = 0;
    repeat (40) begin
      run_cycle();
      if (popped) begin
        checks++;
        if (popped_bus[31:0] !== prev + 32'd4) begin
          failures++; $display("FAIL stream_order got=%h exp=%h", popped_bus[31:0], prev + 32'd4);
        end
        prev = popped_bus[31:0];
      end
    end
    checks++;
    if (pops - p0 < 37) begin
      failures++; $display("FAIL stream_rate got=%0d exp>=37 pops in 40 cycles", pops - p0);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] prev;
    bit first = 1;
    k_allow = 0;
    repeat (10) run_cycle();
    #1;
    checks++;
    if (inst_sram_req !== 1'b0 || fs_to_ds_valid !== 1'b1) begin
      failures++; $display("FAIL backpressure_full req=%b valid=%b exp 0/1", inst_sram_req, fs_to_ds_valid);
    end
    k_allow = 1;
    repeat (20) begin
      run_cycle();
      if (popped) begin
        if (!first) begin
          checks++;
          if (popped_bus[31:0] !== prev + 32'd4) begin
            failures++; $display("FAIL backpressure_order got=%h exp=%h", popped_bus[31:0], prev + 32'd4);
          end
        end
        first = 0; prev = popped_bus[31:0];
      end
    end
  endtask

  task automatic test_ex_cancel();
    do_reset();
    k_allow = 1; k_lat_min = 3; k_lat_max = 3;
    wait_inflight("ex_cancel_setup", 2);
    k_ex = 1; run_cycle(); k_ex = 0;
    wait_pop("ex_cancel_next_pc", {1'b0, 5'd0, mem_word(EX_PC), EX_PC});
  endtask

  task automatic test_eret_misaligned();
    k_lat_min = 2; k_lat_max = 2;
    wait_inflight("eret_setup", 1);
    k_eret = 1; k_epc = 32'h80001002; run_cycle(); k_eret = 0;
    wait_pop("eret_exc_entry", {1'b1, 5'h04, 32'h0, 32'h80001002});
    repeat (8) begin
      run_cycle();
      #1;
      checks++;
      if (inst_sram_req !== 1'b0) begin
        failures++; $display("FAIL eret_halt req=%b exp 0", inst_sram_req);
      end
    end
    k_br = 1; k_brt = 32'h80000100; run_cycle(); k_br = 0;
    wait_pop("halt_release", {1'b0, 5'd0, mem_word(32'h80000100), 32'h80000100});
  endtask

  task automatic test_priority();
    int n = 0;
    k_lat_min = 2; k_lat_max = 3;
    while (!(mem.size() > 0 && mem[0].due <= cyc) && n < 40) begin run_cycle(); n++; end
    checks++;
    if (!(mem.size() > 0 && mem[0].due <= cyc)) begin
      failures++; $display("FAIL priority_setup timeout");
    end
    k_ex = 1; k_br = 1; k_brt = 32'h80000200; run_cycle(); k_ex = 0; k_br = 0;
    wait_pop("priority_ex_wins", {1'b0, 5'd0, mem_word(EX_PC), EX_PC});
  endtask

  task automatic test_reset_inflight();
    k_lat_min = 4; k_lat_max = 4; k_allow = 0;
    wait_inflight("reset_inflight_setup", 2);
    @(negedge clk); #2;
    reset = 1;
    #1;
    checks++;
    if (inst_sram_req !== 1'b0 || fs_to_ds_valid !== 1'b0) begin
      failures++; $display("FAIL reset_async req=%b valid=%b exp 0/0", inst_sram_req, fs_to_ds_valid);
    end
    k_allow = 1;
    do_reset();
    #1;
    checks++;
    if (inst_sram_req !== 1'b1 || inst_sram_addr !== RST_PC) begin
      failures++; $display("FAIL reset_restart req=%b addr=%h exp 1/%h", inst_sram_req, inst_sram_addr, RST_PC);
    end
    k_lat_min = 1; k_lat_max = 1;
    wait_pop("reset_restart_pop", {1'b0, 5'd0, mem_word(RST_PC), RST_PC});
  endtask

  task automatic test_random();
    int r;
    k_aok_rand = 1; k_lat_min = 1; k_lat_max = 4;
    repeat (3000) begin
      k_allow = ($urandom_range(0, 3) != 0);
      k_stall = ($urandom_range(0, 7) == 0);
      r = $urandom_range(0, 99);
      k_ex = (r < 2); k_eret = (r >= 2 && r < 4); k_br = (r >= 4 && r < 7);
      k_epc = {$urandom, 2'b00} | (($urandom_range(0, 3) == 0) ? 32'd2 : 32'd0);
      k_brt = {$urandom} & 32'hffff_fffc;
      run_cycle();
    end
    k_ex = 0; k_eret = 0; k_br = 0; k_stall = 0; k_aok_rand = 0; k_allow = 1;
    repeat (10) run_cycle();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_stream();
    test_backpressure();
    test_ex_cancel();
    test_eret_misaligned();
    test_priority();
    test_reset_inflight();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
